wb_vector_slave: RTL
====================

Name: wb_vector_slave

Overview:
Wishbone classic slave that sits directly downstream of the host Wishbone master (the XYZ/XYZW burst writer). It accepts 3-word (short flow) or 4-word (long flow) component bursts, packs them into one vector, and hands it over a valid/ready interface to the GPU-side memory writer. It back-pressures the bus by withholding ACK_O when its single output register is still occupied.

Parameters:
DATA_W, 32, width of DAT_I, ADR_I, each vector component and oVectorAddr.

Ports:
Clock  in  1  system clock, all logic on posedge.
Reset  in  1  synchronous, active-low reset.
iShortFlow  in  1  1 = 3-component burst (X,Y,Z), 0 = 4-component burst (X,Y,Z,W).
CYC_I  in  1  Wishbone cycle.
STB_I  in  1  Wishbone strobe.
ACK_O  out  1  Wishbone acknowledge, registered, one-cycle pulse per beat.
DAT_I  in  DATA_W  write data, one component per beat.
ADR_I  in  DATA_W  destination vector address.
oVectorValid  out  1  packed vector available.
iVectorReady  in  1  consumer accepts vector when high with oVectorValid.
oVectorAddr  out  DATA_W  ADR_I latched on beat 0.
oVectorData  out  4*DATA_W  {W,Z,Y,X}, X in LSBs; W = 0 for short flow.
oVectorShort  out  1  iShortFlow latched on beat 0.
oBusy  out  1  partial vector in collection (beat count != 0).

Behaviour:
- Reset low at a clock edge: ACK_O=0, oVectorValid=0, oVectorAddr=0, oVectorData=0, oVectorShort=0, oBusy=0, beat counter=0, state IDLE. Applies mid-burst; partial vector discarded.
- Beat count N = 3 when latched short flag = 1, else 4. iShortFlow and ADR_I sampled only on beat 0; later changes ignored until next vector.
- States: IDLE (count 0), COLLECT (0 < count < N), STALL (last beat pending, output register full).
- Accept condition: CYC_I & STB_I & ~ACK_O & can_accept. can_accept = 1 unless the pending beat is beat N-1 and oVectorValid=1 and iVectorReady=0.
- On accept edge: ACK_O<=1 for exactly one cycle; DAT_I captured into component slot [count]; count increments. Latency STB_I-high to ACK_O-high = 1 cycle. ACK_O never high two consecutive cycles.
- Beat N-1 accepted: on the same edge, output register loads {W,Z,Y,X}, addr and short flag; oVectorValid<=1; count returns to 0 (IDLE).
- oVectorValid clears on an edge where iVectorReady=1, unless a new vector loads on that same edge, in which case it stays 1 with new contents (no bubble, no loss).
- STALL: last beat held off (ACK_O=0) while output full and not ready; leaves STALL and acks the cycle after iVectorReady rises.
- CYC_I low while count != 0: abort, count <= 0, partial data discarded, output register untouched.
- STB_I high with CYC_I low: ignored.
- Outputs stable while oVectorValid=1 and iVectorReady=0.

Optional Feature:
WBS_VECTOR_COUNT_EN: when defined, adds output oVectorCount [15:0], reset to 0, incremented on every edge where a vector is loaded into the output register, wrapping 0xFFFF -> 0x0000; aborted bursts not counted. When undefined, the port and counter do not exist; all other behaviour identical.

Test Plan:
- Long flow, ADR_I=0x100, DAT_I 0x11,0x22,0x33,0x44 with master-style STB (STB <= ~ACK), iVectorReady=1 -> 4 ACK pulses, each 1 cycle after STB; oVectorValid one cycle, oVectorData={0x44,0x33,0x22,0x11}, oVectorAddr=0x100, oVectorShort=0.
- Short flow, DAT_I 0xA,0xB,0xC -> 3 ACKs, oVectorData={0,0xC,0xB,0xA}, oVectorShort=1; iShortFlow toggled to 0 after beat 0 has no effect.
- iVectorReady=0, two back-to-back long bursts -> first vector held; second burst acks beats 0-2, beat 3 ACK withheld; raise iVectorReady 5 cycles later -> beat 3 acked next cycle, second vector replaces first with oVectorValid continuously 1.
- Drop CYC_I after 2 beats of long flow, then full burst 0x5,0x6,0x7,0x8 -> only {0x8,0x7,0x6,0x5} emitted; oBusy 1 during partial, 0 after abort.
- Assert Reset=0 mid-burst after beat 1 with oVectorValid=1 -> all outputs 0 next edge; following burst starts at slot X.
- WBS_VECTOR_COUNT_EN defined, 3 complete + 1 aborted burst -> oVectorCount=3; preload to 0xFFFF then one vector -> 0x0000.

Source files
------------

// File: rtl/wb_vector_slave.sv
// Wishbone classic slave packing 3/4-beat component bursts into one vector for a valid/ready consumer.
// Optional WBS_VECTOR_COUNT_EN adds a 16-bit loaded-vector counter output (oVectorCount).
module wb_vector_slave #(
    parameter int DATA_W = 32
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                iShortFlow,
    input  logic                CYC_I,
    input  logic                STB_I,
    output logic                ACK_O,
    input  logic [DATA_W-1:0]   DAT_I,
    input  logic [DATA_W-1:0]   ADR_I,
    output logic                oVectorValid,
    input  logic                iVectorReady,
    output logic [DATA_W-1:0]   oVectorAddr,
    output logic [4*DATA_W-1:0] oVectorData,
    output logic                oVectorShort,
    output logic                oBusy
`ifdef WBS_VECTOR_COUNT_EN
    ,
    output logic [15:0]         oVectorCount
`endif
);

    // Consumer handshake: a vector transfers on an edge where oVectorValid and iVectorReady are both high;
    // oVectorValid never drops and the output fields never change until that transfer happens.
    typedef enum logic [1:0] {IDLE, COLLECT, STALL} state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        count;
    logic              short_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] comp_x;
    logic [DATA_W-1:0] comp_y;
    logic [DATA_W-1:0] comp_z;
    logic              last_pending;
    logic              can_accept;
    logic              accept;
    logic              load;

    always_comb begin
        last_pending = (count == (short_q ? 2'd2 : 2'd3));
        can_accept   = !(last_pending && oVectorValid && !iVectorReady);
        accept       = CYC_I && STB_I && !ACK_O && can_accept;
        load         = accept && last_pending;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = COLLECT;
            end
            COLLECT: begin
                if (!CYC_I || load) begin
                    state_next = IDLE;
                end else if (last_pending && STB_I && !ACK_O && !can_accept) begin
                    state_next = STALL;
                end
            end
            STALL: begin
                if (!CYC_I || load) begin
                    state_next = IDLE;
                end else if (can_accept) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign oBusy = (state != IDLE);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            ACK_O        <= 1'b0;
            count        <= 2'd0;
            short_q      <= 1'b0;
            addr_q       <= '0;
            comp_x       <= '0;
            comp_y       <= '0;
            comp_z       <= '0;
            oVectorValid <= 1'b0;
            oVectorAddr  <= '0;
            oVectorData  <= '0;
            oVectorShort <= 1'b0;
        end else begin
            ACK_O <= accept;
            // A load on the same edge as a consume keeps valid high with the new contents.
            if (load) begin
                oVectorValid <= 1'b1;
            end else if (iVectorReady) begin
                oVectorValid <= 1'b0;
            end
            if (!CYC_I) begin
                count <= 2'd0;
            end else if (accept) begin
                if (count == 2'd0) begin
                    short_q <= iShortFlow;
                    addr_q  <= ADR_I;
                end
                case (count)
                    2'd0:    comp_x <= DAT_I;
                    2'd1:    comp_y <= DAT_I;
                    2'd2:    comp_z <= DAT_I;
                    default: ;
                endcase
                if (load) begin
                    count        <= 2'd0;
                    oVectorAddr  <= addr_q;
                    oVectorShort <= short_q;
                    // The final beat goes straight into the output register without a slot of its own.
                    oVectorData  <= short_q ? {{DATA_W{1'b0}}, DAT_I, comp_y, comp_x}
                                            : {DAT_I, comp_z, comp_y, comp_x};
                end else begin
                    count <= count + 2'd1;
                end
            end
        end
    end

`ifdef WBS_VECTOR_COUNT_EN
    logic [15:0] vector_count;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            vector_count <= 16'd0;
        end else if (load) begin
            vector_count <= vector_count + 16'd1;
        end
    end

    assign oVectorCount = vector_count;
`endif

endmodule
